// File: rtl/dist_ranging_scheduler.sv
// Round-robin ranging sequencer: fires one distance sensor at a time and
// closes its slot on reply silence or on timeout, then waits a quiet gap.
module dist_ranging_scheduler #(
  parameter int unsigned NUM_CH         = 8,
  parameter int unsigned TRIG_CYCLES    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned IDLE_CYCLES    = 52083,
  parameter int unsigned GAP_CYCLES     = 50000,
  parameter int unsigned CNT_W          = 24,
  localparam int unsigned CH_W          = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              continuous,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] rx_line,
  output logic [NUM_CH-1:0] trig,
  output logic [CH_W-1:0]   cur_ch,
  output logic              busy,
  output logic              slot_done,
  output logic              slot_timeout,
  output logic              round_done
);

  localparam int unsigned PTR_W = CH_W + 1;

  localparam logic [CNT_W-1:0] TrigLast = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] ToLast   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StTrig,
    StWaitRx,
    StRxActive,
    StGap
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]   cur_q, cur_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic              rd_q, rd_d;
  logic              rend_q, rend_d;
  logic [NUM_CH-1:0] rx_meta_q, rx_sync_q;

  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;
  logic              more_above;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;
  logic              rx_now;
  logic              slot_end;
  logic              slot_end_to;

  // Two-flop synchronizer; lines idle high so reset to ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= '1;
      rx_sync_q <= '1;
    end else begin
      rx_meta_q <= rx_line;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Channel scans: lowest enabled channel at or above ptr, and whether any
  // enabled channel lies above the current one (end-of-round detection).
  always_comb begin
    sel_found  = 1'b0;
    sel_ch     = '0;
    more_above = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i] && (PTR_W'(i) >= ptr_q)) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(i);
      end
      if (ch_mask[i] && (CH_W'(i) > cur_q)) begin
        more_above = 1'b1;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idle_q  <= '0;
      ptr_q   <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      rd_q    <= 1'b0;
      rend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      to_q    <= to_d;
      rd_q    <= rd_d;
      rend_q  <= rend_d;
    end
  end

  // Next-state logic: slot sequencing, timeout and reply-idle detection.
  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    done_d      = 1'b0;
    to_d        = to_q;
    rd_d        = 1'b0;
    rend_d      = rend_q;
    slot_end    = 1'b0;
    slot_end_to = 1'b0;

    // Counter saturates rather than wrapping.
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    cnt_d       = cnt_inc;
    timeout_hit = (cnt_q >= ToLast);
    rx_now      = rx_sync_q[cur_q];

    if (!enable) begin
      state_d = StIdle;
      ptr_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d = '0;
          if ((start || continuous) && (|ch_mask)) begin
            state_d = StSelect;
            ptr_d   = '0;
          end
        end
        StSelect: begin
          cnt_d  = '0;
          idle_d = '0;
          if (sel_found) begin
            cur_d   = sel_ch;
            state_d = StTrig;
          end else if (continuous && (|ch_mask)) begin
            ptr_d = '0;
          end else begin
            state_d = StIdle;
            ptr_d   = '0;
          end
        end
        StTrig: begin
          if (timeout_hit) begin
            slot_end    = 1'b1;
            slot_end_to = 1'b1;
          end else if (cnt_q == TrigLast) begin
            state_d = StWaitRx;
          end
        end
        StWaitRx: begin
          if (timeout_hit) begin
            slot_end    = 1'b1;
            slot_end_to = 1'b1;
          end else if (!rx_now) begin
            state_d = StRxActive;
            idle_d  = '0;
          end
        end
        StRxActive: begin
          // Timeout is checked first so it wins over a coincident idle end.
          if (timeout_hit) begin
            slot_end    = 1'b1;
            slot_end_to = 1'b1;
          end else if (!rx_now) begin
            idle_d = '0;
          end else if (idle_q == IdleLast) begin
            slot_end = 1'b1;
          end else begin
            idle_d = idle_q + CNT_W'(1);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            if (rend_q) begin
              ptr_d   = '0;
              state_d = continuous ? StSelect : StIdle;
            end else begin
              ptr_d   = {1'b0, cur_q} + PTR_W'(1);
              state_d = StSelect;
            end
          end
        end
        default: state_d = StIdle;
      endcase

      if (slot_end) begin
        state_d = StGap;
        cnt_d   = '0;
        done_d  = 1'b1;
        to_d    = slot_end_to;
        rd_d    = !more_above;
        rend_d  = !more_above;
      end
    end
  end

  // Outputs: trigger is decoded from state, pulses come from registers.
  always_comb begin
    trig = '0;
    if (state_q == StTrig) begin
      trig[cur_q] = 1'b1;
    end
  end

  assign busy         = (state_q != StIdle);
  assign cur_ch       = cur_q;
  assign slot_done    = done_q;
  assign slot_timeout = to_q;
  assign round_done   = rd_q;

endmodule

// File: tb/tb_dist_ranging_scheduler.sv
// Bench for dist_ranging_scheduler: directed scenarios plus randomized traffic,
// checked every cycle against a slot-age based reference model.
module tb_dist_ranging_scheduler;

  localparam int NUM_CH = 8;
  localparam int TRIG   = 4;
  localparam int TO     = 100;
  localparam int IDLE   = 10;
  localparam int GAP    = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       enable = 1'b0;
  logic       continuous = 1'b0;
  logic       start = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic [7:0] rx_line = 8'hFF;
  logic [7:0] trig;
  logic [2:0] cur_ch;
  logic       busy, slot_done, slot_timeout, round_done;

  always #5 clk = ~clk;

  dist_ranging_scheduler #(
    .NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TO),
    .IDLE_CYCLES(IDLE), .GAP_CYCLES(GAP), .CNT_W(24)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .continuous(continuous),
    .start(start), .ch_mask(ch_mask), .rx_line(rx_line), .trig(trig),
    .cur_ch(cur_ch), .busy(busy), .slot_done(slot_done),
    .slot_timeout(slot_timeout), .round_done(round_done)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- sensor responder ----------------
  // 0 silent, 1 reply window, 2 short glitch every 9 cycles, 3 random noise
  int         resp_mode = 0;
  int         resp_dly  = 20;
  int         resp_len  = 8;
  int         r_age     = 1000;
  logic [7:0] r_ch      = 8'h00;
  logic [7:0] r_prev    = 8'h00;

  always @(posedge clk) begin : responder
    logic [7:0] rx;
    #1;
    if (trig != 8'h00 && r_prev == 8'h00) begin
      r_age = 0;
      r_ch  = trig;
    end else begin
      r_age++;
    end
    r_prev = trig;
    rx = 8'hFF;
    case (resp_mode)
      1: if (r_age >= resp_dly && r_age < resp_dly + resp_len) rx = rx & ~r_ch;
      2: if (r_age >= 10 && ((r_age - 10) % 9) == 0) rx = rx & ~r_ch;
      3: rx = 8'($urandom) | 8'($urandom);
      default: rx = 8'hFF;
    endcase
    rx_line = rx;
  end

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 choosing a channel, 2 inside a slot, 3 quiet gap.
  // Inside a slot everything is expressed as the slot age (cycles since trigger start).
  int         ph = 0, ch = 0, ptr = 0, age = 0, last_low = 0, gap_age = 0;
  bit         seen = 0, rend = 0;
  logic [7:0] m1 = 8'hFF, m2 = 8'hFF, smp;
  logic [7:0] e_trig = 8'h00;
  logic [2:0] e_cur = 3'd0;
  logic       e_busy = 0, e_done = 0, e_to = 0, e_rd = 0;

  always @(posedge clk or negedge reset_n) begin : model
    int  pick;
    bit  more;
    bit  fin, fin_to;
    if (!reset_n) begin
      ph = 0; ch = 0; ptr = 0; m1 = 8'hFF; m2 = 8'hFF;
      e_done = 0; e_to = 0; e_rd = 0;
    end else begin
      smp = m2;
      m2  = m1;
      m1  = rx_line;
      e_done = 0;
      e_rd   = 0;
      if (!enable) begin
        ph  = 0;
        ptr = 0;
      end else begin
        case (ph)
          0: if ((start || continuous) && ch_mask != 8'h00) begin
            ph  = 1;
            ptr = 0;
          end
          1: begin
            pick = -1;
            for (int i = ptr; i < NUM_CH; i++) begin
              if (ch_mask[i]) begin
                pick = i;
                break;
              end
            end
            if (pick >= 0) begin
              ch = pick; ph = 2; age = 0; seen = 0;
            end else if (continuous && ch_mask != 8'h00) begin
              ptr = 0;
            end else begin
              ph = 0; ptr = 0;
            end
          end
          2: begin
            if (age >= TRIG && !smp[ch]) begin
              seen = 1;
              last_low = age;
            end
            fin = 0; fin_to = 0;
            if (age >= TO - 1) begin
              fin = 1; fin_to = 1;
            end else if (seen && (age - last_low) == IDLE) begin
              fin = 1;
            end
            if (fin) begin
              more = 0;
              for (int i = ch + 1; i < NUM_CH; i++) if (ch_mask[i]) more = 1;
              rend = !more;
              e_done = 1; e_to = fin_to; e_rd = rend;
              ph = 3; gap_age = 0;
            end else begin
              age++;
            end
          end
          3: begin
            if (gap_age == GAP - 1) begin
              if (rend) begin
                ptr = 0;
                ph  = continuous ? 1 : 0;
              end else begin
                ptr = ch + 1;
                ph  = 1;
              end
            end else begin
              gap_age++;
            end
          end
          default: ph = 0;
        endcase
      end
    end
    e_trig = (ph == 2 && age < TRIG) ? 8'(1 << ch) : 8'h00;
    e_busy = (ph != 0);
    e_cur  = 3'(ch);
  end

  // ---------------- checking helpers ----------------
  int         cyc = 0, n_done = 0, n_rd = 0, n_trig = 0, n_busy = 0;
  int         rise_cyc = 0, done_cyc = 0, rd_cyc = 0;
  logic [7:0] rise_vec = 8'h00, mon_prev = 8'h00;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, plus event bookkeeping.
  task automatic run_compare();
    logic [13:0] act, exp;
    forever begin
      @(negedge clk);
      cyc++;
      if (trig != 8'h00 && mon_prev == 8'h00) begin
        rise_cyc = cyc;
        rise_vec = trig;
      end
      mon_prev = trig;
      if (trig != 8'h00) n_trig++;
      if (busy) n_busy++;
      if (slot_done) begin n_done++; done_cyc = cyc; end
      if (round_done) begin n_rd++; rd_cyc = cyc; end
      if (reset_n) begin
        act = {trig, cur_ch, busy, slot_done, slot_timeout, round_done};
        exp = {e_trig, e_cur, e_busy, e_done, e_to, e_rd};
        checks++;
        if (act !== exp) begin
          errors++;
          if (errors < 30)
            $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h", cyc, act, exp);
        end
      end
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  task automatic wait_trig(input logic [7:0] want, input string name);
    int n = 0;
    while ((trig & want) == 8'h00 && n < 200) begin
      tick();
      n++;
    end
    chk(name, ((trig & want) != 8'h00), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d0, r0, t0, b0, n;
    fork
      run_compare();
    join_none

    #1 reset_n = 1'b0;
    tick(3);
    chk("reset_trig", trig, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cur_ch", cur_ch, 0);
    chk("reset_pulses", {slot_done, slot_timeout, round_done}, 0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick(2);

    // Two-channel round with replies.
    resp_mode = 1; resp_dly = 20; resp_len = 8;
    ch_mask = 8'h05;
    d0 = n_done; r0 = n_rd; t0 = n_trig;
    pulse_start();
    wait_idle(1000, "s1_finish");
    chk("s1_trig_cycles", n_trig - t0, 8);
    chk("s1_slot_dones", n_done - d0, 2);
    chk("s1_round_dones", n_rd - r0, 1);
    chk("s1_round_with_last", rd_cyc, done_cyc);
    chk("s1_timeout_flag", slot_timeout, 0);
    tick(3);

    // Silent sensor: timeout exactly TO cycles after trigger start.
    resp_mode = 0;
    ch_mask = 8'h80;
    pulse_start();
    wait_idle(1000, "s2_finish");
    chk("s2_trig_vec", rise_vec, 8'h80);
    chk("s2_latency", done_cyc - rise_cyc, 100);
    chk("s2_round_cycle", rd_cyc - rise_cyc, 100);
    chk("s2_timeout_flag", slot_timeout, 1);
    tick(3);

    // Continuous two-channel looping.
    resp_mode = 1;
    ch_mask = 8'h03;
    d0 = n_done; r0 = n_rd;
    continuous = 1'b1;
    n = 0;
    while ((n_done - d0) < 6 && n < 3000) begin
      tick();
      n++;
    end
    chk("s3_slot_dones", n_done - d0, 6);
    chk("s3_round_dones", n_rd - r0, 3);
    continuous = 1'b0;
    wait_idle(1000, "s3_finish");
    tick(3);

    // Glitching reply keeps restarting the idle count.
    resp_mode = 2;
    ch_mask = 8'h04;
    pulse_start();
    wait_idle(1000, "s4_finish");
    chk("s4_timeout_flag", slot_timeout, 1);
    chk("s4_latency", done_cyc - rise_cyc, 100);
    tick(3);

    // Enable dropped during a trigger pulse.
    resp_mode = 1;
    ch_mask = 8'h08;
    d0 = n_done;
    pulse_start();
    wait_trig(8'h08, "s5_trig_seen");
    enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("s5_abort_trig", trig, 0);
    chk("s5_abort_busy", busy, 0);
    tick(20);
    chk("s5_no_slot_done", n_done - d0, 0);
    enable = 1'b1;
    ch_mask = 8'h28;
    pulse_start();
    wait_trig(8'hFF, "s5_resume_seen");
    chk("s5_resume_ch", trig, 8'h08);
    wait_idle(1000, "s5_finish");
    tick(3);

    // Empty mask never leaves idle.
    ch_mask = 8'h00;
    b0 = n_busy; t0 = n_trig;
    pulse_start();
    tick(10);
    chk("s6_busy_cycles", n_busy - b0, 0);
    chk("s6_trig_cycles", n_trig - t0, 0);

    // Start while busy is ignored.
    ch_mask = 8'h01;
    d0 = n_done;
    pulse_start();
    tick(10);
    pulse_start();
    wait_idle(1000, "s7_finish");
    tick(5);
    chk("s7_single_round", n_done - d0, 1);

    // Asynchronous reset mid-slot.
    ch_mask = 8'h04;
    pulse_start();
    wait_trig(8'h04, "s8_trig_seen");
    #2 reset_n = 1'b0;
    #1;
    chk("s8_async_trig", trig, 0);
    chk("s8_async_busy", busy, 0);
    chk("s8_async_cur_ch", cur_ch, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      ch_mask    = 8'($urandom);
      if ($urandom_range(4) == 0) ch_mask = 8'h00;
      continuous = ($urandom_range(5) == 0);
      resp_mode  = $urandom_range(3);
      resp_dly   = 4 + $urandom_range(39);
      resp_len   = 1 + $urandom_range(14);
      enable     = 1'b1;
      pulse_start();
      n = 50 + $urandom_range(300);
      for (int c = 0; c < n; c++) begin
        if ($urandom_range(199) == 0) enable = ~enable;
        if ($urandom_range(99) == 0) ch_mask = 8'($urandom);
        if ($urandom_range(149) == 0) start = 1'b1;
        tick();
        start = 1'b0;
      end
      continuous = 1'b0;
    end

    enable = 1'b0;
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dist_ranging_scheduler.md
Name: dist_ranging_scheduler

Overview:
- Round-robin ranging sequencer for the eight serial distance sensors on the GPIO headers.
- Fires one sensor at a time through its trigger/RX line, so the sensors never range simultaneously and cannot crosstalk.
- Watches that sensor's serial reply line to decide when its slot ends, or times the slot out.
- Sits between the processor control registers (enable, mask, mode) and the dist*_RXD pins; the UART cores still decode the reply bytes.

Parameters:
- NUM_CH, 8, number of sensor channels; ch_mask, rx_line and trig are NUM_CH wide.
- TRIG_CYCLES, 1000, trigger pulse width in clk cycles (20 us at 50 MHz).
- TIMEOUT_CYCLES, 2500000, maximum slot length, counted from trigger start (50 ms).
- IDLE_CYCLES, 52083, consecutive idle-high cycles after reply activity that end a slot (one byte time at 9600 baud).
- GAP_CYCLES, 50000, quiet gap between slots (1 ms).
- CNT_W, 24, width of the shared slot/gap counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  master enable; low aborts any activity.
- continuous  in  1  1 = loop rounds forever; 0 = single round per start.
- start  in  1  single-cycle pulse that begins one round; ignored while busy.
- ch_mask  in  NUM_CH  1 = channel participates.
- rx_line  in  NUM_CH  sensor reply lines, idle-high, already polarity-corrected; asynchronous.
- trig  out  NUM_CH  one-hot trigger to the sensor RX pins; active high.
- cur_ch  out  3  index of the channel owning the current slot.
- busy  out  1  high in any state except IDLE.
- slot_done  out  1  one-cycle pulse at the end of each slot.
- slot_timeout  out  1  valid with slot_done: 1 = ended by timeout, 0 = reply seen.
- round_done  out  1  one-cycle pulse with the last slot_done of a round.

Behaviour:
- Reset: trig=0, cur_ch=0, busy=0, slot_done=0, slot_timeout=0, round_done=0, ptr=0, state IDLE.
- rx_line passes through a 2-flop synchronizer; all rx decisions use the synchronized value, so there is 2 cycles of latency.
- IDLE:
  - Leave on (start & enable) or (enable & continuous), with ptr=0.
  - If ch_mask==0, stay in IDLE and keep busy=0.
- SELECT (1 cycle):
  - Choose the lowest enabled channel >= ptr, using ch_mask sampled this cycle; latch it into cur_ch.
  - If none exists, end the round: go to IDLE, or if continuous, restart from ptr=0.
  - The counter clears on leaving SELECT.
- TRIG: trig[cur_ch]=1 for exactly TRIG_CYCLES cycles, then WAIT_RX. The timeout count starts at the first TRIG cycle.
- WAIT_RX: synchronized rx low -> RX_ACTIVE.
- RX_ACTIVE:
  - Idle counter clears on every low sample.
  - IDLE_CYCLES consecutive high samples -> slot end with slot_timeout=0.
- Timeout: in TRIG, WAIT_RX or RX_ACTIVE, once elapsed slot cycles reach TIMEOUT_CYCLES -> slot end with slot_timeout=1. Timeout wins if it coincides with the idle end.
- Slot end:
  - slot_done=1 for one cycle, with slot_timeout held until the next slot_done.
  - round_done pulses in the same cycle if no enabled channel has index > cur_ch.
  - Go to GAP.
- GAP:
  - GAP_CYCLES cycles, trig=0.
  - Then ptr=cur_ch+1, or ptr=0 after round_done.
  - Next state: SELECT if round not done; after round_done, SELECT if (continuous & enable), else IDLE.
- enable low in any state: next cycle trig=0, state IDLE, ptr=0, no slot_done or round_done.
- Mask changes take effect at the next SELECT. The current slot always completes.
- Width rule: the counter saturates at its maximum and never wraps.

Test Plan (all parameters overridden: TRIG_CYCLES=4, TIMEOUT_CYCLES=100, IDLE_CYCLES=10, GAP_CYCLES=5):
- Reset release, enable=1, ch_mask=8'h05, start pulse, each selected rx_line pulled low 20 cycles after its trigger for 8 cycles -> trig[0] high exactly 4 cycles, then trig[2]; two slot_done pulses with slot_timeout=0; round_done with the second; then busy=0.
- ch_mask=8'h80, start, rx_line held high -> trig[7] high 4 cycles; slot_done with slot_timeout=1 exactly 100 cycles after trig rose; round_done in the same cycle.
- continuous=1, ch_mask=8'h03, sensors replying -> sequence ch0, ch1, ch0, ch1…; gap of ≥5 cycles with trig=0 between slots; round_done every second slot_done.
- Reply glitching low every 9 cycles from cycle 10 onward -> slot ends only by timeout (slot_timeout=1), showing the idle counter restarts on every low sample.
- enable dropped during TRIG of ch3 -> trig=0 on the next cycle, busy=0, no slot_done; re-enable plus start resumes at the lowest enabled channel.
- ch_mask=0 with start -> busy stays 0 and trig stays 0. A start pulse while busy is ignored (no extra round). Asserting reset_n low mid-slot clears all outputs asynchronously.
